// File: rtl/bit_stream_pkg.sv
// Shared types and constants for the bit stream packer and its word FIFO.
package bit_stream_pkg;

    // Packer state: IDLE holds no pending bits, FILL holds a partial word.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } pack_state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with registered occupancy; head is presented whenever valid.
import bit_stream_pkg::*;

module word_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic             pop_ok;
    logic             push_ok;

    assign valid   = (count != '0);
    assign full    = (count == OCC_W'(FIFO_DEPTH));
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop & valid;
    // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
    assign push_ok = push & (~full | pop_ok);

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bit_stream_packer.sv
// Packs accepted serial bits LSB-first into words, queues them in a 2-entry FIFO,
// and tracks the run length of identical bits to flag a stuck stream.
//
//  state | meaning
//  IDLE  | no bits pending, bit_cnt = 0
//  FILL  | partial word held, 0 < bit_cnt < WIDTH
import bit_stream_pkg::*;

module bit_stream_packer #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter int STUCK_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] run_len,
    output logic             stuck_flag
);

    localparam int BC_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};

    pack_state_t      state;
    logic [BC_W-1:0]  bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic             last_bit;

    logic [BC_W-1:0]  nxt_cnt;
    logic [WIDTH-1:0] nxt_sreg;
    logic             push;
    logic             pop;
    logic             fifo_full;

    // Fold the incoming bit in first; a flush then sees the word including it.
    always_comb begin
        nxt_sreg = sreg;
        nxt_cnt  = bit_cnt;
        if (bit_valid) begin
            nxt_sreg = sreg | (WIDTH'(bit_in) << bit_cnt);
            nxt_cnt  = bit_cnt + 1'b1;
        end
        push = (nxt_cnt == BC_W'(WIDTH)) ||
               (flush && ((state == FILL) || bit_valid));
    end

    assign pop = word_valid & word_ready;

    // Packer state, bit position and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sreg    <= '0;
        end else if (clr) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sreg    <= '0;
        end else if (push) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sreg    <= '0;
        end else begin
            state   <= (nxt_cnt != '0) ? FILL : IDLE;
            bit_cnt <= nxt_cnt;
            sreg    <= nxt_sreg;
        end
    end

    // Sticky overflow when a completed word finds the FIFO full and nothing leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                overflow <= 1'b0;
        else if (clr)                           overflow <= 1'b0;
        else if (push && fifo_full && !pop)     overflow <= 1'b1;
    end

    // Run-length counter over accepted bits; run_len of 0 marks "no previous bit".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len  <= '0;
            last_bit <= 1'b0;
        end else if (clr) begin
            run_len  <= '0;
            last_bit <= 1'b0;
        end else if (bit_valid) begin
            last_bit <= bit_in;
            if ((run_len == '0) || (bit_in != last_bit)) run_len <= CNT_W'(1);
            else if (run_len != RUN_MAX)                 run_len <= run_len + 1'b1;
        end
    end

    // Stuck flag trails run_len by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      stuck_flag <= 1'b0;
        else if (clr) stuck_flag <= 1'b0;
        else          stuck_flag <= (run_len >= CNT_W'(STUCK_LIMIT));
    end

    word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .push_data (nxt_sreg),
        .pop       (pop),
        .head      (word_out),
        .valid     (word_valid),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_bit_stream_packer.sv
// Bench for bit_stream_packer: directed scenarios plus random traffic, all checked
// against a queue-based model of pending bits, FIFO contents and run length.
module tb_bit_stream_packer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int LIMIT = 16;
    localparam int RMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             bit_in;
    logic             bit_valid;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic             overflow;
    logic [CNT_W-1:0] run_len;
    logic             stuck_flag;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_bits[$];
    logic [7:0]  m_fifo[$];
    int          m_run;
    bit          m_last;
    bit          m_ovf;
    bit          m_stuck;

    bit_stream_packer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .STUCK_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .overflow   (overflow),
        .run_len    (run_len),
        .stuck_flag (stuck_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_fifo.delete();
        m_run   = 0;
        m_last  = 0;
        m_ovf   = 0;
        m_stuck = 0;
    endtask

    task automatic model_edge(input bit c, input bit bv, input bit b, input bit fl, input bit rdy);
        bit         do_pop;
        bit         do_push;
        logic [7:0] w;
        if (c) begin
            model_reset();
            return;
        end
        do_pop  = (m_fifo.size() > 0) && rdy;
        m_stuck = (m_run >= LIMIT);
        if (bv) begin
            m_bits.push_back(b);
            if (m_run == 0 || b != m_last) m_run = 1;
            else if (m_run < RMAX)         m_run = m_run + 1;
            m_last = b;
        end
        do_push = (m_bits.size() == WIDTH) || (fl && m_bits.size() > 0);
        w = '0;
        if (do_push) begin
            foreach (m_bits[i]) w[i] = m_bits[i];
            m_bits.delete();
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (do_push) begin
            if (m_fifo.size() < 2) m_fifo.push_back(w);
            else                   m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        chk("word_valid", word_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) chk("word_out", word_out, m_fifo[0]);
        chk("overflow", overflow, m_ovf);
        chk("run_len", run_len, m_run);
        chk("stuck_flag", stuck_flag, m_stuck);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input bit c, input bit bv, input bit b, input bit fl, input bit rdy);
        clr = c; bit_valid = bv; bit_in = b; flush = fl; word_ready = rdy;
        @(posedge clk);
        model_edge(c, bv, b, fl, rdy);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy);
        logic [7:0] v;
        v = w;
        for (int i = 0; i < WIDTH; i++) step(0, 1, v[i], 0, rdy);
    endtask

    initial begin
        rst = 1; clr = 0; bit_in = 0; bit_valid = 0; flush = 0; word_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset_word_out", word_out, 0);
        chk("reset_valid", word_valid, 0);
        chk("reset_run_len", run_len, 0);
        compare_all();

        // 1: bits 1,0,1,1,0,0,1,0 -> 0x4D visible for exactly one cycle
        send_word(8'h4D, 1);
        chk("t1_word", word_out, 8'h4D);
        chk("t1_valid", word_valid, 1);
        step(0, 0, 0, 0, 1);
        chk("t1_valid_once", word_valid, 0);

        // 2: backpressure, third word dropped
        step(1, 0, 0, 0, 0);
        send_word(8'h01, 0);
        send_word(8'h02, 0);
        send_word(8'h03, 0);
        chk("t2_overflow", overflow, 1);
        chk("t2_head", word_out, 8'h01);
        step(0, 0, 0, 0, 1);
        chk("t2_second", word_out, 8'h02);
        step(0, 0, 0, 0, 1);
        chk("t2_empty", word_valid, 0);
        chk("t2_ovf_sticky", overflow, 1);
        step(1, 0, 0, 0, 1);
        chk("t2_ovf_clr", overflow, 0);

        // 3: sixteen ones then a zero
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 1);
        chk("t3_run16", run_len, 16);
        chk("t3_stuck_lag", stuck_flag, 0);
        step(0, 0, 0, 0, 1);
        chk("t3_stuck", stuck_flag, 1);
        step(0, 1, 0, 0, 1);
        chk("t3_run1", run_len, 1);
        step(0, 0, 0, 0, 1);
        chk("t3_unstuck", stuck_flag, 0);

        // 4: saturation
        for (int i = 0; i < 300; i++) step(0, 1, 0, 0, 1);
        chk("t4_sat", run_len, 255);
        step(0, 0, 0, 0, 1);
        chk("t4_stuck", stuck_flag, 1);

        // 5: partial flush, fresh word, idle flush
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("t5_partial", word_out, 8'h07);
        send_word(8'hA5, 1);
        chk("t5_fresh", word_out, 8'hA5);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        chk("t5_idle_flush", word_valid, 0);

        // 6: async reset mid-word with a full FIFO
        send_word(8'h3C, 0);
        send_word(8'hC3, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
        #2;
        rst = 1;
        #1;
        chk("t6_rst_valid", word_valid, 0);
        chk("t6_rst_word", word_out, 0);
        chk("t6_rst_run", run_len, 0);
        chk("t6_rst_ovf", overflow, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        send_word(8'hFF, 0);
        chk("t6_word", word_out, 8'hFF);
        step(0, 0, 0, 0, 1);
        chk("t6_single", word_valid, 0);

        // Random traffic with runs, flushes, clears and backpressure
        begin
            bit cur;
            cur = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 9) < 3) cur = ~cur;
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 3) != 0,
                     cur,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 2) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
